str_store_unit: RTL and testbench
=================================

Name: str_store_unit

Overview:
- Data-memory store block of the milestone-1 processor: writes a 16-bit register value (Reg2) into word-addressed data memory at the address held in Reg1.
- Also provides one registered read port so later stages and benches can read stored data back.
- Storage array is named Memory so benches can dump it hierarchically with $writememh.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 16, address width in bits.
- DEPTH, 64, number of words implemented; addresses >= DEPTH are out of range.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- wr_en  input  1  store request, sampled on clk rising edge
- addr  input  ADDR_W  store word address (Reg1)
- data_in  input  DATA_W  store data (Reg2)
- rd_addr  input  ADDR_W  read word address
- rd_data  output  DATA_W  registered read data
- wr_ack  output  1  pulses high the cycle after an accepted in-range store

Behaviour:
- Reset: sampled on a rising clk edge with rst_n=0. Clears every Memory word to 0, rd_data to 0 and wr_ack to 0. Stores requested in a reset cycle are dropped.
- Store: on a rising edge with rst_n=1, wr_en=1 and addr<DEPTH, Memory[addr] <= data_in. wr_ack=1 for exactly the following cycle; otherwise wr_ack=0.
- Store latency: 1 clock; the new value is visible in Memory after the edge.
- Full DATA_W word written; no byte enables; no sign or width conversion.
- Out-of-range store (addr>=DEPTH): memory unchanged, wr_ack=0, no aliasing or wrap-around.
- Read: rd_data <= Memory[rd_addr] on every rising edge out of reset, 1-cycle latency. Out-of-range rd_addr returns 0.
- Read and write to the same address on the same edge: read-first; rd_data returns the old word and the new word is visible one cycle later.
- Back-to-back stores: one per cycle, no stalls. Repeated stores to one address: the last one wins.
- wr_en=0: memory holds its contents indefinitely.

Optional Feature:
- Macro STR_ADDR_CHECK_EN.
- Defined: adds output addr_err (1 bit, sticky). It sets on any wr_en=1 with addr>=DEPTH, or on any read with rd_addr>=DEPTH, and clears only on reset (reset value 0).
- Undefined: no addr_err port. Out-of-range behaviour is otherwise identical (ignored store, read returns 0).

Decomposition:
- Shared package str_pkg: DATA_W/ADDR_W defaults, data_t and addr_t typedefs, MEM_DEPTH constant.
- One natural sub-module: str_mem_array, the DEPTH x DATA_W register array with synchronous clear, one write port and a registered read port.
- The top level holds the range check, the wr_ack and addr_err logic, and exposes the array as Memory.

Test Plan:
- Reset held 2 cycles -> rd_data=0, wr_ack=0, Memory[0..63] all 0000.
- Stores addr 0..5 = AAAA, 00AA, 00EE, 00CC, 00BB, 00FF, one per cycle -> wr_ack high each following cycle; Memory dump shows those six values then 0000s.
- Read-back rd_addr=3 -> rd_data=00CC one cycle later; same-edge store 1234 to addr 3 while reading 3 -> old 00CC returned, then 1234.
- Store to addr 0x0040 with data BEEF -> no Memory change, wr_ack=0, rd_addr=0x0040 returns 0000; with STR_ADDR_CHECK_EN, addr_err=1 and it stays 1.
- wr_en=0 with addr=2, data=FFFF -> Memory[2] remains 00EE.
- Reset asserted after the stores -> all words read 0000; addr_err cleared.

Source files
------------

// File: rtl/str_pkg.sv
// Shared definitions for the data-memory store unit: default widths, depth and word/address types.
package str_pkg;

    localparam int STR_DATA_W = 16;
    localparam int STR_ADDR_W = 16;
    localparam int MEM_DEPTH  = 64;

    typedef logic [STR_DATA_W-1:0] data_t;
    typedef logic [STR_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/str_mem_array.sv
// DEPTH x DATA_W register array with synchronous clear, one write port and a registered
// read port; callers pass pre-validated indices and the enables that qualify them.
module str_mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wrEn_i,
    input  logic [IDX_W-1:0]  wrIdx_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic              rdEn_i,
    input  logic [IDX_W-1:0]  rdIdx_i,
    output logic [DATA_W-1:0] rdData_o,
    output logic [DATA_W-1:0] mem_o [DEPTH]
);

    logic [DATA_W-1:0] Memory [DEPTH];
    logic [DATA_W-1:0] rdData_q;

    // Read samples the pre-edge contents, so a same-edge write to the read address is read-first.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                Memory[i] <= '0;
            end
            rdData_q <= '0;
        end else begin
            if (wrEn_i) begin
                Memory[wrIdx_i] <= wrData_i;
            end
            rdData_q <= rdEn_i ? Memory[rdIdx_i] : '0;
        end
    end

    assign rdData_o = rdData_q;
    assign mem_o    = Memory;

endmodule

// File: rtl/str_store_unit.sv
// Data-memory store block: writes Reg2 to Memory[Reg1] with a registered read-back port.
// Define STR_ADDR_CHECK_EN to add the sticky addr_err output for out-of-range accesses.
module str_store_unit
    import str_pkg::*;
#(
    parameter int DATA_W = STR_DATA_W,
    parameter int ADDR_W = STR_ADDR_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_ack
`ifdef STR_ADDR_CHECK_EN
    ,
    output logic              addr_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] Memory [DEPTH];
    logic              wrInRange;
    logic              rdInRange;
    logic              wrAck_d;
    logic              wrAck_q;

    // Full-width compare so high address bits can never alias onto a low word.
    always_comb begin
        wrInRange = (32'(addr) < DEPTH);
        rdInRange = (32'(rd_addr) < DEPTH);
        wrAck_d   = wr_en && wrInRange;
    end

    str_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_memArray (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .wrEn_i   (wrAck_d),
        .wrIdx_i  (addr[IDX_W-1:0]),
        .wrData_i (data_in),
        .rdEn_i   (rdInRange),
        .rdIdx_i  (rd_addr[IDX_W-1:0]),
        .rdData_o (rd_data),
        .mem_o    (Memory)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrAck_q <= 1'b0;
        end else begin
            wrAck_q <= wrAck_d;
        end
    end

    assign wr_ack = wrAck_q;

`ifdef STR_ADDR_CHECK_EN
    logic addrErr_d;
    logic addrErr_q;

    // Sticky: any out-of-range store request or read keeps the flag set until reset.
    always_comb begin
        addrErr_d = addrErr_q || (wr_en && !wrInRange) || !rdInRange;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addrErr_q <= 1'b0;
        end else begin
            addrErr_q <= addrErr_d;
        end
    end

    assign addr_err = addrErr_q;
`endif

endmodule

// File: tb/tb_str_store_unit.sv
// Directed self-checking bench for str_store_unit; also covers addr_err when STR_ADDR_CHECK_EN is defined.
module tb_str_store_unit;
    import str_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  wr_en;
    addr_t addr;
    data_t data_in;
    addr_t rd_addr;
    data_t rd_data;
    logic  wr_ack;
`ifdef STR_ADDR_CHECK_EN
    logic  addr_err;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    str_store_unit #(
        .DATA_W (16),
        .ADDR_W (16),
        .DEPTH  (64)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .addr    (addr),
        .data_in (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_ack  (wr_ack)
`ifdef STR_ADDR_CHECK_EN
        ,
        .addr_err (addr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs, lets a rising edge take them, then returns on the falling edge.
    task automatic applyStimulus(input logic we, input addr_t a, input data_t d, input addr_t ra);
        wr_en   = we;
        addr    = a;
        data_in = d;
        rd_addr = ra;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic int countNonZero(input int first, input int last);
        int n = 0;
        for (int i = first; i <= last; i++) begin
            if (dut.Memory[i] !== 16'h0000) n++;
        end
        return n;
    endfunction

    data_t storeVals [6] = '{16'hAAAA, 16'h00AA, 16'h00EE, 16'h00CC, 16'h00BB, 16'h00FF};

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        addr    = '0;
        data_in = '0;
        rd_addr = '0;
        @(negedge clk);

        // Reset held for two cycles
        applyStimulus(1'b0, 16'd0, 16'h0000, 16'd0);
        applyStimulus(1'b0, 16'd0, 16'h0000, 16'd0);
        checkOutput("resetRdData", 32'(rd_data), 32'h0);
        checkOutput("resetWrAck", 32'(wr_ack), 32'h0);
        checkOutput("resetMemClear", 32'(countNonZero(0, 63)), 32'd0);
`ifdef STR_ADDR_CHECK_EN
        checkOutput("resetAddrErr", 32'(addr_err), 32'h0);
`endif

        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, addr_t'(i), storeVals[i], 16'd0);
            checkOutput($sformatf("storeAck%0d", i), 32'(wr_ack), 32'h1);
            checkOutput($sformatf("storeMem%0d", i), 32'(dut.Memory[i]), 32'(storeVals[i]));
        end
        checkOutput("untouchedWords", 32'(countNonZero(6, 63)), 32'd0);

        applyStimulus(1'b0, 16'd0, 16'h0000, 16'd3);
        checkOutput("readAddr3", 32'(rd_data), 32'h00CC);
        checkOutput("idleAck", 32'(wr_ack), 32'h0);

        // Same-edge store and read of address 3 returns the old word first
        applyStimulus(1'b1, 16'd3, 16'h1234, 16'd3);
        checkOutput("readFirstOld", 32'(rd_data), 32'h00CC);
        checkOutput("readFirstAck", 32'(wr_ack), 32'h1);
        applyStimulus(1'b0, 16'd0, 16'h0000, 16'd3);
        checkOutput("readFirstNew", 32'(rd_data), 32'h1234);

`ifdef STR_ADDR_CHECK_EN
        checkOutput("addrErrClean", 32'(addr_err), 32'h0);
`endif
        applyStimulus(1'b1, 16'h0040, 16'hBEEF, 16'h0040);
        checkOutput("oorAck", 32'(wr_ack), 32'h0);
        checkOutput("oorRead", 32'(rd_data), 32'h0000);
        checkOutput("oorNoAlias", 32'(dut.Memory[0]), 32'hAAAA);
        checkOutput("oorHighWords", 32'(countNonZero(6, 63)), 32'd0);
`ifdef STR_ADDR_CHECK_EN
        checkOutput("addrErrSet", 32'(addr_err), 32'h1);
`endif

        applyStimulus(1'b0, 16'd2, 16'hFFFF, 16'd2);
        checkOutput("holdRead", 32'(rd_data), 32'h00EE);
        checkOutput("holdMem", 32'(dut.Memory[2]), 32'h00EE);
        checkOutput("holdAck", 32'(wr_ack), 32'h0);
`ifdef STR_ADDR_CHECK_EN
        checkOutput("addrErrSticky", 32'(addr_err), 32'h1);
`endif

        applyStimulus(1'b1, 16'd5, 16'h1111, 16'd0);
        applyStimulus(1'b1, 16'd5, 16'h2222, 16'd0);
        checkOutput("lastWinsMem", 32'(dut.Memory[5]), 32'h2222);
        checkOutput("lastWinsAck", 32'(wr_ack), 32'h1);

        applyStimulus(1'b1, 16'd63, 16'h7777, 16'd63);
        checkOutput("topWordAck", 32'(wr_ack), 32'h1);
        applyStimulus(1'b0, 16'd0, 16'h0000, 16'd63);
        checkOutput("topWordRead", 32'(rd_data), 32'h7777);

        // Reset after stores; the store requested during reset is dropped
        rst_n = 1'b0;
        applyStimulus(1'b1, 16'd1, 16'h9999, 16'd1);
        checkOutput("rstAgainAck", 32'(wr_ack), 32'h0);
        checkOutput("rstAgainRead", 32'(rd_data), 32'h0000);
        checkOutput("rstAgainMem", 32'(countNonZero(0, 63)), 32'd0);
`ifdef STR_ADDR_CHECK_EN
        checkOutput("rstAgainAddrErr", 32'(addr_err), 32'h0);
`endif
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'd0, 16'h0000, 16'd1);
        checkOutput("postRstRead", 32'(rd_data), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
